// File: rtl/product_accumulator.sv
// Product accumulator: sums a run of unsigned multiplier products with
// saturation and presents the total through a valid/ready result port.
module product_accumulator #(
  parameter int PROD_W = 7,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     sumExt;

  // One spare bit on the adder exposes the carry that signals saturation.
  assign sumExt = {1'b0, acc_q} + (ACC_W+1)'(in_prod);

  // Next-state logic: run setup in IDLE, beat accumulation in ACCUM,
  // result handshake in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (sumExt[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sumExt[ACC_W-1:0];
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that wipes any aborted run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 12-bit and an 8-bit accumulator share
// the same stimulus and are compared against a reference model each cycle.
module tb_product_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [6:0] in_prod;
  logic       out_ready;

  logic        inReady12, outValid12, outOvf12, busy12;
  logic [11:0] outSum12;
  logic        inReady8, outValid8, outOvf8, busy8;
  logic [7:0]  outSum8;

  int checks   = 0;
  int failures = 0;

  typedef enum {M_IDLE, M_ACCUM, M_DONE} mstate_t;
  typedef struct {
    int sum12;
    bit ovf12;
    int sum8;
    bit ovf8;
  } result_t;

  mstate_t mState = M_IDLE;
  int      mCnt   = 0;
  int      mSum12 = 0;
  bit      mOvf12 = 0;
  int      mSum8  = 0;
  bit      mOvf8  = 0;
  result_t scoreboard[$];

  product_accumulator #(.PROD_W(7), .ACC_W(12)) dut12 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(inReady12), .in_prod(in_prod),
    .out_valid(outValid12), .out_ready(out_ready), .out_sum(outSum12),
    .out_ovf(outOvf12), .busy(busy12)
  );

  product_accumulator #(.PROD_W(7), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(inReady8), .in_prod(in_prod),
    .out_valid(outValid8), .out_ready(out_ready), .out_sum(outSum8),
    .out_ovf(outOvf8), .busy(busy8)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge,
  // then compare every output of both instances after the edge.
  task automatic applyStimulus(input bit r, input bit st, input int ln,
                               input bit v, input int p, input bit rdy);
    result_t res;
    if (!r && mState == M_DONE && rdy) begin
      checks++;
      assert (scoreboard.size() > 0) else begin
        failures++;
        $error("[TB] FAIL sb_empty observed=%0d expected=%0d", 0, 1);
      end
      if (scoreboard.size() > 0) begin
        res = scoreboard.pop_front();
        checkOutput("result_sum12", int'(outSum12), res.sum12);
        checkOutput("result_ovf12", int'(outOvf12), int'(res.ovf12));
        checkOutput("result_sum8",  int'(outSum8),  res.sum8);
        checkOutput("result_ovf8",  int'(outOvf8),  int'(res.ovf8));
      end
    end

    rst       = r;
    start     = st;
    len       = 4'(ln);
    in_valid  = v;
    in_prod   = 7'(p);
    out_ready = rdy;

    if (r) begin
      mState = M_IDLE;
      mCnt   = 0;
      mSum12 = 0; mOvf12 = 0;
      mSum8  = 0; mOvf8  = 0;
    end else begin
      case (mState)
        M_IDLE: if (st) begin
          mCnt   = (ln == 0) ? 16 : ln;
          mSum12 = 0; mOvf12 = 0;
          mSum8  = 0; mOvf8  = 0;
          mState = M_ACCUM;
        end
        M_ACCUM: if (v) begin
          mSum12 += p;
          if (mSum12 > 4095) begin mSum12 = 4095; mOvf12 = 1; end
          mSum8 += p;
          if (mSum8 > 255) begin mSum8 = 255; mOvf8 = 1; end
          mCnt--;
          if (mCnt == 0) begin
            res.sum12 = mSum12; res.ovf12 = mOvf12;
            res.sum8  = mSum8;  res.ovf8  = mOvf8;
            scoreboard.push_back(res);
            mState = M_DONE;
          end
        end
        M_DONE: if (rdy) mState = M_IDLE;
        default: mState = M_IDLE;
      endcase
    end

    @(posedge clk);
    #1;
    checkOutput("out_valid12", int'(outValid12), int'(mState == M_DONE));
    checkOutput("in_ready12",  int'(inReady12),  int'(mState == M_ACCUM));
    checkOutput("busy12",      int'(busy12),     int'(mState != M_IDLE));
    checkOutput("out_sum12",   int'(outSum12),   mSum12);
    checkOutput("out_ovf12",   int'(outOvf12),   int'(mOvf12));
    checkOutput("out_valid8",  int'(outValid8),  int'(mState == M_DONE));
    checkOutput("in_ready8",   int'(inReady8),   int'(mState == M_ACCUM));
    checkOutput("busy8",       int'(busy8),      int'(mState != M_IDLE));
    checkOutput("out_sum8",    int'(outSum8),    mSum8);
    checkOutput("out_ovf8",    int'(outOvf8),    int'(mOvf8));
  endtask

  // Directed scenario sequence.
  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over start, in_valid and out_ready.
    applyStimulus(1, 1, 3, 1, 50, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 9, 1);

    // Basic run: 60 + 4 + 35 = 99.
    applyStimulus(0, 1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 60, 0);
    applyStimulus(0, 0, 0, 1, 4, 0);
    applyStimulus(0, 0, 0, 1, 35, 0);
    checkOutput("basic_sum", int'(outSum12), 99);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Full-length run: len=0 means 16 beats of 105; a 17th beat is refused.
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 1, 105, 0);
    checkOutput("full_sum", int'(outSum12), 1680);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Backpressure and input gaps.
    applyStimulus(0, 1, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 20, 0);
    applyStimulus(0, 0, 0, 0, 99, 0);
    applyStimulus(0, 0, 0, 0, 99, 0);
    applyStimulus(0, 0, 0, 1, 30, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("bp_sum", int'(outSum12), 50);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Saturation on the 8-bit instance, then a clean follow-up run.
    applyStimulus(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 127, 0);
    checkOutput("sat_sum8", int'(outSum8), 255);
    checkOutput("sat_ovf8", int'(outOvf8), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5, 0);
    checkOutput("post_sat_ovf8", int'(outOvf8), 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Reset after two of four beats, then a fresh single-beat run.
    applyStimulus(0, 1, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 10, 0);
    applyStimulus(0, 0, 0, 1, 11, 0);
    applyStimulus(1, 1, 2, 1, 12, 1);
    checkOutput("abort_sum", int'(outSum12), 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 9, 0);
    checkOutput("after_abort_sum", int'(outSum12), 9);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // start pulses in ACCUM and DONE have no effect.
    applyStimulus(0, 1, 2, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 7, 0);
    applyStimulus(0, 1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 8, 0);
    applyStimulus(0, 1, 5, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 0);
    checkOutput("restart_sum", int'(outSum12), 3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    checkOutput("sb_drained", scoreboard.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
